// File: rtl/clk_div_ratio_ctrl_if.sv
// Ratio-request handshake between the system controller / register file and
// the divider configuration sequencer.
interface clk_div_ratio_ctrl_if #(
    parameter int unsigned RATIO_W = 8
);
    logic               i_cfg_valid;
    logic [RATIO_W-1:0] i_cfg_ratio;
    logic               o_cfg_ready;

    modport master (
        output i_cfg_valid,
        output i_cfg_ratio,
        input  o_cfg_ready
    );

    modport slave (
        input  i_cfg_valid,
        input  i_cfg_ratio,
        output o_cfg_ready
    );
endinterface

// File: rtl/clk_div_ratio_ctrl.sv
// Divider ratio sequencer: applies new ratios on a falling divided-clock edge,
// in bypass, or after a timeout. Define CLK_DIV_CTRL_GATE_EN to gate o_clk_gate_en.
module clk_div_ratio_ctrl #(
    parameter int unsigned RATIO_W       = 8,
    parameter int unsigned TIMEOUT       = 512,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned RESET_RATIO   = 1
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst_n,
    clk_div_ratio_ctrl_if.slave    cfg,
    input  logic                   i_div_clk,
    output logic [RATIO_W-1:0]     o_div_ratio,
    output logic                   o_clk_gate_en,
    output logic                   o_busy,
    output logic                   o_applied,
    output logic                   o_timeout
);
    localparam int unsigned WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned SCNT_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [RATIO_W-1:0] RESET_VAL  = (RESET_RATIO == 0) ? RATIO_W'(1) : RATIO_W'(RESET_RATIO);
    localparam logic [WCNT_W-1:0]  WAIT_LAST  = WCNT_W'(TIMEOUT - 1);
    localparam logic [SCNT_W-1:0]  SETTLE_LAST = SCNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EDGE,
        APPLY,
        SETTLE
    } state_t;

    state_t             state;
    logic [RATIO_W-1:0] pending_q;
    logic [RATIO_W-1:0] req_ratio;
    logic [WCNT_W-1:0]  wait_cnt;
    logic [SCNT_W-1:0]  settle_cnt;
    logic               div_q;
    logic               fall_det;

    assign req_ratio       = (cfg.i_cfg_ratio == '0) ? RATIO_W'(1) : cfg.i_cfg_ratio;
    assign fall_det        = div_q & ~i_div_clk;
    assign cfg.o_cfg_ready = (state == IDLE);
    assign o_busy          = (state != IDLE);

`ifdef CLK_DIV_CTRL_GATE_EN
    logic gate_q;
    assign o_clk_gate_en = gate_q;
`else
    assign o_clk_gate_en = 1'b1;
`endif

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            pending_q   <= RESET_VAL;
            o_div_ratio <= RESET_VAL;
            o_applied   <= 1'b0;
            o_timeout   <= 1'b0;
            wait_cnt    <= '0;
            settle_cnt  <= '0;
            div_q       <= 1'b0;
`ifdef CLK_DIV_CTRL_GATE_EN
            gate_q      <= 1'b1;
`endif
        end else begin
            div_q     <= i_div_clk;
            o_applied <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg.i_cfg_valid) begin
                        pending_q <= req_ratio;
                        o_timeout <= 1'b0;
                        wait_cnt  <= '0;
                        if (req_ratio == o_div_ratio) begin
                            // Same ratio: still pulse o_applied, but keep the clock running.
                            state     <= APPLY;
                            o_applied <= 1'b1;
                        end else if (o_div_ratio <= RATIO_W'(1)) begin
                            state       <= APPLY;
                            o_div_ratio <= req_ratio;
                            o_applied   <= 1'b1;
`ifdef CLK_DIV_CTRL_GATE_EN
                            gate_q      <= 1'b0;
`endif
                        end else begin
                            state <= WAIT_EDGE;
                        end
                    end
                end
                WAIT_EDGE: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (fall_det || (wait_cnt == WAIT_LAST)) begin
                        state       <= APPLY;
                        o_div_ratio <= pending_q;
                        o_applied   <= 1'b1;
                        o_timeout   <= ~fall_det;
`ifdef CLK_DIV_CTRL_GATE_EN
                        gate_q      <= 1'b0;
`endif
                    end
                end
                APPLY: begin
                    state      <= SETTLE;
                    settle_cnt <= '0;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    if (settle_cnt == SETTLE_LAST) begin
                        state  <= IDLE;
`ifdef CLK_DIV_CTRL_GATE_EN
                        gate_q <= 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
